// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, op codes
// and default geometry.
package mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_WAIT   = 2'd1,
        MS_ACCESS = 2'd2,
        MS_DONE   = 2'd3
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port synchronous RAM; the read register doubles as the
// responder's DataOut, so it alone is cleared by reset (the array is not).
module mem_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the Read/Write strobes: edge-detects a request,
// waits WAIT_STATES cycles, accesses mem_array, then pulses Ready.
// Optional MEM_STATS_EN adds RdCount/WrCount access counters.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Ready,
    output logic              Busy,
    output logic              ReqErr
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       RdCount,
    output logic [15:0]       WrCount
`endif
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_t        state;
    mem_state_t        state_d;
    mem_op_t           op_q;
    logic              rd_q;
    logic              wr_q;
    logic              rd_rise;
    logic              wr_rise;
    logic              accept;
    logic              collide;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              do_access;
    logic              mem_we;
    logic              mem_re;

    assign rd_rise = Read & ~rd_q;
    assign wr_rise = Write & ~wr_q;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        collide = 1'b0;
        case (state)
            MS_IDLE: begin
                if (rd_rise && wr_rise) begin
                    collide = 1'b1;
                end else if (rd_rise || wr_rise) begin
                    accept  = 1'b1;
                    state_d = (WAIT_STATES > 0) ? MS_WAIT : MS_ACCESS;
                end
            end
            MS_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_d = MS_ACCESS;
                end
            end
            MS_ACCESS: state_d = MS_DONE;
            MS_DONE:   state_d = MS_IDLE;
            default:   state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= MS_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Edge history keeps updating outside IDLE so a held strobe never refires.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            Busy     <= 1'b0;
            Ready    <= 1'b0;
            ReqErr   <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            rd_q  <= Read;
            wr_q  <= Write;
            Ready <= (state == MS_DONE);
            if (collide) begin
                ReqErr <= 1'b1;
            end
            if (accept) begin
                Busy <= 1'b1;
            end else if (state == MS_DONE) begin
                Busy <= 1'b0;
            end
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == MS_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            addr_q <= Address;
            data_q <= DataIn;
            op_q   <= wr_rise ? OP_WR : OP_RD;
        end
    end

    // Clear in the ACCESS cycle must still suppress the write.
    assign do_access = (state == MS_ACCESS) && !Clear;
    assign mem_we    = do_access && (op_q == OP_WR);
    assign mem_re    = do_access && (op_q == OP_RD);

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (Clock),
        .rst   (Clear),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (DataOut)
    );

`ifdef MEM_STATS_EN
    always_ff @(posedge Clock) begin
        if (Clear) begin
            RdCount <= 16'd0;
            WrCount <= 16'd0;
        end else begin
            if (mem_re) begin
                RdCount <= RdCount + 16'd1;
            end
            if (mem_we) begin
                WrCount <= WrCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model tracks the
// WAIT_STATES=1 instance every cycle; two extra instances cover WAIT_STATES 0 and 15.
module tb_mem_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        clear;
    logic        rd, wr;
    logic [8:0]  addr;
    logic [31:0] din, dout;
    logic        ready, busy, req_err;

    logic [1:0]  rd_x, wr_x, ready_x, busy_x, err_x;
    logic [8:0]  addr_x [2];
    logic [31:0] din_x  [2];
    logic [31:0] dout_x [2];

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
    logic [15:0] rd_cnt_x [2];
    logic [15:0] wr_cnt_x [2];
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .Clock(clk), .Clear(clear), .Read(rd), .Write(wr), .Address(addr), .DataIn(din),
        .DataOut(dout), .Ready(ready), .Busy(busy), .ReqErr(req_err)
`ifdef MEM_STATS_EN
        , .RdCount(rd_cnt), .WrCount(wr_cnt)
`endif
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut_ws0 (
        .Clock(clk), .Clear(clear), .Read(rd_x[0]), .Write(wr_x[0]), .Address(addr_x[0]),
        .DataIn(din_x[0]), .DataOut(dout_x[0]), .Ready(ready_x[0]), .Busy(busy_x[0]),
        .ReqErr(err_x[0])
`ifdef MEM_STATS_EN
        , .RdCount(rd_cnt_x[0]), .WrCount(wr_cnt_x[0])
`endif
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(15)) dut_ws15 (
        .Clock(clk), .Clear(clear), .Read(rd_x[1]), .Write(wr_x[1]), .Address(addr_x[1]),
        .DataIn(din_x[1]), .DataOut(dout_x[1]), .Ready(ready_x[1]), .Busy(busy_x[1]),
        .ReqErr(err_x[1])
`ifdef MEM_STATS_EN
        , .RdCount(rd_cnt_x[1]), .WrCount(wr_cnt_x[1])
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Transaction model: one accepted request at edge acc_at owns the
    // responder until Ready, which appears after edge acc_at+WS+2.
    int          cyc = 0;
    int          acc_at = -100;
    bit          acc_wr;
    logic [8:0]  acc_addr;
    logic [31:0] acc_data;
    logic [31:0] m_mem [int];
    logic [31:0] m_dout = '0;
    bit          m_dknown = 1'b0;
    bit          m_err = 1'b0;
    bit          m_prd = 1'b0;
    bit          m_pwr = 1'b0;

    initial forever begin
        bit rr, wrr;
        @(posedge clk);
        cyc++;
        if (clear) begin
            acc_at   = -100;
            m_err    = 1'b0;
            m_dout   = '0;
            m_dknown = 1'b1;
            m_prd    = 1'b0;
            m_pwr    = 1'b0;
        end else begin
            rr  = rd && !m_prd;
            wrr = wr && !m_pwr;
            if (cyc == acc_at + WS + 1) begin
                if (acc_wr) begin
                    m_mem[int'(acc_addr)] = acc_data;
                end else if (m_mem.exists(int'(acc_addr))) begin
                    m_dout   = m_mem[int'(acc_addr)];
                    m_dknown = 1'b1;
                end else begin
                    m_dknown = 1'b0;
                end
            end
            if (cyc > acc_at + WS + 2) begin
                if (rr && wrr) begin
                    m_err = 1'b1;
                end else if (rr || wrr) begin
                    acc_at   = cyc;
                    acc_wr   = wrr;
                    acc_addr = addr;
                    acc_data = din;
                end
            end
            m_prd = rd;
            m_pwr = wr;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ready_vs_model", ready, (cyc == acc_at + WS + 2));
            check("busy_vs_model", busy, (cyc >= acc_at && cyc <= acc_at + WS + 1));
            check("reqerr_vs_model", req_err, m_err);
            if (m_dknown) begin
                check("dataout_vs_model", dout, m_dout);
            end
        end
    end

    // Pulse one request on the main instance; lat counts edges from accept to Ready.
    task automatic do_op(input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                         output int lat, output int bcnt);
        @(posedge clk); #2;
        rd = !is_wr; wr = is_wr; addr = a; din = d;
        @(posedge clk); #2;
        rd = 1'b0; wr = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (ready) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic run_x(input int k, input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                         input int poke, output int lat, output int rcnt);
        @(posedge clk); #2;
        if (is_wr) wr_x[k] = 1'b1; else rd_x[k] = 1'b1;
        addr_x[k] = a; din_x[k] = d;
        @(posedge clk); #2;
        rd_x[k] = 1'b0; wr_x[k] = 1'b0;
        lat  = -1;
        rcnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ready_x[k]) begin
                rcnt++;
                if (lat < 0) lat = i - 1;
            end
            if (i == poke) rd_x[k] = 1'b1;
            if (i == poke + 1) rd_x[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, rcnt;
`ifdef MEM_STATS_EN
        logic [15:0] rd_before;
`endif
        clear = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        rd_x = '0; wr_x = '0;
        for (int k = 0; k < 2; k++) begin
            addr_x[k] = '0; din_x[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_reqerr", req_err, 1'b0);
        check("reset_dataout", dout, 32'h0);
        @(posedge clk); #2;
        clear  = 1'b0;
        chk_en = 1'b1;

        do_op(1'b1, 9'h010, 32'h1234_5678, lat, bcnt);
        do_op(1'b1, 9'h054, 32'h0000_0097, lat, bcnt);
        check("wr_latency", lat, 3);
        check("wr_busy_cycles", bcnt, 3);
        do_op(1'b0, 9'h054, 32'h0, lat, bcnt);
        check("rd_latency", lat, 3);
        check("rd_busy_cycles", bcnt, 3);
        check("rd_data_054", dout, 32'h0000_0097);

        // Held Read strobe: one access only.
        do_op(1'b1, 9'h0AA, 32'hA5A5_0001, lat, bcnt);
`ifdef MEM_STATS_EN
        rd_before = rd_cnt;
`endif
        @(posedge clk); #2;
        rd = 1'b1; addr = 9'h0AA;
        rcnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ready) rcnt++;
            if (i == 9) rd = 1'b0;
        end
        check("held_ready_pulses", rcnt, 1);
        check("held_data_0aa", dout, 32'hA5A5_0001);
`ifdef MEM_STATS_EN
        check("held_rdcount_delta", rd_cnt - rd_before, 16'd1);
`endif

        // Simultaneous rise: error, no access.
        @(posedge clk); #2;
        rd = 1'b1; wr = 1'b1; addr = 9'h054; din = 32'h0000_0BAD;
        rcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) rcnt++;
        end
        rd = 1'b0; wr = 1'b0;
        check("collide_no_ready", rcnt, 0);
        check("collide_reqerr", req_err, 1'b1);
        do_op(1'b0, 9'h054, 32'h0, lat, bcnt);
        check("collide_mem_kept", dout, 32'h0000_0097);
        check("reqerr_sticky", req_err, 1'b1);
        @(posedge clk); #2;
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        @(negedge clk);
        check("reqerr_cleared", req_err, 1'b0);

        // Clear during the WAIT cycle aborts the write.
        @(posedge clk); #2;
        wr = 1'b1; addr = 9'h010; din = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        wr = 1'b0; clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) rcnt++;
            if (i == 0) check("abort_busy_low", busy, 1'b0);
        end
        check("abort_no_ready", rcnt, 0);
        do_op(1'b0, 9'h010, 32'h0, lat, bcnt);
        check("abort_mem_kept", dout, 32'h1234_5678);

        // Address extremes.
        do_op(1'b1, 9'h1FF, 32'hFFFF_FFFF, lat, bcnt);
        do_op(1'b1, 9'h000, 32'h0000_0001, lat, bcnt);
        do_op(1'b0, 9'h1FF, 32'h0, lat, bcnt);
        check("rd_1ff", dout, 32'hFFFF_FFFF);
        do_op(1'b0, 9'h000, 32'h0, lat, bcnt);
        check("rd_000", dout, 32'h0000_0001);
        chk_en = 1'b0;

        // WAIT_STATES = 0.
        run_x(0, 1'b1, 9'h033, 32'hCAFE_0001, 0, lat, rcnt);
        check("ws0_wr_latency", lat, 2);
        check("ws0_wr_pulses", rcnt, 1);
        run_x(0, 1'b0, 9'h033, 32'h0, 0, lat, rcnt);
        check("ws0_rd_latency", lat, 2);
        check("ws0_rd_data", dout_x[0], 32'hCAFE_0001);

        // WAIT_STATES = 15, with a Read poked in while Busy.
        run_x(1, 1'b1, 9'h044, 32'h0000_0005, 5, lat, rcnt);
        check("ws15_wr_latency", lat, 17);
        check("ws15_ignored_req", rcnt, 1);
        check("ws15_busy_poke_dout", dout_x[1], 32'h0);
        run_x(1, 1'b0, 9'h044, 32'h0, 0, lat, rcnt);
        check("ws15_rd_latency", lat, 17);
        check("ws15_rd_data", dout_x[1], 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
